// File: rtl/qkv_ram_stream_reader_pkg.sv
`default_nettype none
// qkv_ram_stream_reader_pkg: shared widths, tag type and helpers for the Q/K/V RAM stream reader.
// Rev 1.0
package qkv_ram_stream_reader_pkg;

  localparam int SYSTOLIC_UNIT_NUM = 16;
  localparam int TIME_STEPS        = 4;
  localparam int QKV_RAM_DEPTH     = 768;

  localparam int QKV_DATA_W     = 2 * SYSTOLIC_UNIT_NUM * TIME_STEPS;
  localparam int QKV_ADDR_W     = 10;
  localparam int QKV_FIFO_DEPTH = 4;

  // Sideband carried with every word through the read pipeline and FIFO
  typedef struct packed {
    logic phase;
    logic last;
  } qkv_tag_t;

  localparam int QKV_TAG_W = $bits(qkv_tag_t);

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qkv_rd_skid_fifo.sv
`default_nettype none
// qkv_rd_skid_fifo: synchronous FIFO absorbing BRAM read latency; head is read combinationally.
// Rev 1.0
module qkv_rd_skid_fifo
  import qkv_ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 2 * QKV_DATA_W + QKV_TAG_W,
  parameter int DEPTH = QKV_FIFO_DEPTH
) (
  input  logic                   s_clk,
  input  logic                   s_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  // A full FIFO may still accept a write when the head leaves in the same cycle
  assign rd_en = i_pop & ~o_empty;
  assign wr_en = i_push & (~o_full | rd_en);

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge s_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/qkv_ram_stream_reader.sv
`default_nettype none
// qkv_ram_stream_reader: reads the Q/K/V BRAMs in a QK pass then a V pass and streams words out.
// Rev 1.0
module qkv_ram_stream_reader
  import qkv_ram_stream_reader_pkg::*;
#(
  parameter int DATA_W     = QKV_DATA_W,
  parameter int ADDR_W     = QKV_ADDR_W,
  parameter int DEPTH      = QKV_RAM_DEPTH,
  parameter int FIFO_DEPTH = QKV_FIFO_DEPTH
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_ram_ready,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_q_rdaddr,
  output logic [ADDR_W-1:0] o_k_rdaddr,
  output logic [ADDR_W-1:0] o_v_rdaddr,
  input  logic [DATA_W-1:0] i_q_data,
  input  logic [DATA_W-1:0] i_k_data,
  input  logic [DATA_W-1:0] i_v_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_a,
  output logic [DATA_W-1:0] o_data_b,
  output logic              o_phase,
  output logic              o_last
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_QK    = 3'd2,
    ST_V     = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int                CNT_W     = fifo_cnt_w(FIFO_DEPTH);
  localparam int                ENT_W     = 2 * DATA_W + QKV_TAG_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] qk_addr_q, v_addr_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Two-stage read pipeline: address register stage, then BRAM dout stage
  logic              iss_vld_q;
  qkv_tag_t          iss_tag_q;
  logic              rd_vld_q;
  qkv_tag_t          rd_tag_q;

  logic              issue_qk, issue_v;
  qkv_tag_t          issue_tag;
  logic              room;
  logic [CNT_W:0]    outstanding;

  logic [ENT_W-1:0]  push_data, head;
  logic [DATA_W-1:0] push_a, push_b, head_a, head_b;
  qkv_tag_t          head_tag;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // Every issued read owns a FIFO slot until popped, so the FIFO can never overflow
  assign outstanding = {1'b0, fifo_count} + (CNT_W+1)'(iss_vld_q) + (CNT_W+1)'(rd_vld_q);
  assign room        = (outstanding < (CNT_W+1)'(FIFO_DEPTH)) & ~fifo_full;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    issue_qk  = 1'b0;
    issue_v   = 1'b0;
    issue_tag = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          busy_d   = 1'b1;
          rd_cnt_d = '0;
          state_d  = i_ram_ready ? ST_QK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_ram_ready) state_d = ST_QK;
      end
      ST_QK: begin
        if (room) begin
          issue_qk       = 1'b1;
          issue_tag.last = (rd_cnt_q == LAST_ADDR);
          if (rd_cnt_q == LAST_ADDR) begin
            rd_cnt_d = '0;
            state_d  = ST_V;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_V: begin
        if (room) begin
          issue_v         = 1'b1;
          issue_tag.phase = 1'b1;
          issue_tag.last  = (rd_cnt_q == LAST_ADDR);
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !iss_vld_q && !rd_vld_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      qk_addr_q <= '0;
      v_addr_q  <= '0;
      iss_vld_q <= 1'b0;
      iss_tag_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_tag_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      iss_vld_q <= issue_qk | issue_v;
      iss_tag_q <= issue_tag;
      rd_vld_q  <= iss_vld_q;
      rd_tag_q  <= iss_tag_q;
      if (issue_qk) qk_addr_q <= rd_cnt_q;
      if (issue_v)  v_addr_q  <= rd_cnt_q;
    end
  end

  assign push_a    = rd_tag_q.phase ? i_v_data : i_q_data;
  assign push_b    = rd_tag_q.phase ? '0 : i_k_data;
  assign push_data = {rd_tag_q, push_a, push_b};
  assign pop       = i_ready & ~fifo_empty;

  qkv_rd_skid_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .s_clk   (s_clk),
    .s_rst   (s_rst),
    .i_push  (rd_vld_q),
    .i_wdata (push_data),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign head_tag = qkv_tag_t'(head[ENT_W-1 -: QKV_TAG_W]);
  assign head_a   = head[2*DATA_W-1 -: DATA_W];
  assign head_b   = head[DATA_W-1:0];

  // Head slots are not reset, so gate them to keep idle/reset outputs at zero
  assign o_valid    = ~fifo_empty;
  assign o_data_a   = fifo_empty ? '0 : head_a;
  assign o_data_b   = fifo_empty ? '0 : head_b;
  assign o_phase    = ~fifo_empty & head_tag.phase;
  assign o_last     = ~fifo_empty & head_tag.last;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_q_rdaddr = qk_addr_q;
  assign o_k_rdaddr = qk_addr_q;
  assign o_v_rdaddr = v_addr_q;

endmodule
`default_nettype wire
